// File: rtl/shift_row_buf.sv
// rtl/shift_row_buf.sv - Programmable row-delay line over a circular sample buffer
//
// Optional feature macro: SHIFT_ROW_BUF_ZERO_PAD_EN
//   defined   : data_out reads as zero on every cycle where out_valid is low
//   undefined : data_out always shows the last word read from the buffer
//
// One pointer serves both read and write: an accepted sample first reads the
// word sitting at ptr (written exactly depth accepts earlier), then
// overwrites it. The pointer wraps at the latched depth, so the effective
// delay line length is depth rather than the full storage size.

module shift_row_buf #(
    parameter int DATA_W    = 16,
    parameter int MAX_DEPTH = 256,
    parameter int PTR_W     = $clog2(MAX_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic [PTR_W:0]    cfg_depth,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              primed,
    output logic [PTR_W:0]    fill_cnt
);

    localparam logic [PTR_W:0]   DEPTH_MAX = (PTR_W+1)'(MAX_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Sample storage; never cleared, stale words are masked by fill tracking
    logic [DATA_W-1:0] mem_q [MAX_DEPTH];

    logic [PTR_W:0]    depth_q,     depth_d;
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic [PTR_W:0]    fill_q,      fill_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_out_q,  data_out_d;

    logic              accept;
    logic [PTR_W:0]    cfg_depth_ok;
    logic [DATA_W-1:0] rd_word;
    logic              ptr_last;
    logic              full;

    // A flush on the same cycle swallows the incoming sample
    assign accept = in_valid && !cfg_load;

    // Decode configuration, read port, and wrap/fill status
    always_comb begin
        cfg_depth_ok = cfg_depth;
        if ((cfg_depth == '0) || (cfg_depth > DEPTH_MAX)) begin
            cfg_depth_ok = DEPTH_MAX;
        end
        rd_word  = mem_q[ptr_q];
        ptr_last = ({1'b0, ptr_q} == (depth_q - CNT_ONE));
        full     = (fill_q == depth_q);
    end

    // Next-state: flush has priority over accept; idle cycles hold everything
    // except the single-cycle out_valid strobe
    always_comb begin
        depth_d     = depth_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        data_out_d  = data_out_q;
        if (cfg_load) begin
            depth_d = cfg_depth_ok;
            ptr_d   = '0;
            fill_d  = '0;
        end else if (in_valid) begin
            data_out_d  = rd_word;
            // The word read is genuine only once depth accepts already happened
            out_valid_d = full;
            ptr_d       = ptr_last ? '0 : (ptr_q + PTR_ONE);
            fill_d      = full ? fill_q : (fill_q + CNT_ONE);
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q     <= DEPTH_MAX;
            ptr_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            depth_q     <= depth_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage write; reset only blocks the write, contents are left as-is
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_q[ptr_q] <= data_in;
        end
    end

`ifdef SHIFT_ROW_BUF_ZERO_PAD_EN
    assign data_out = out_valid_q ? data_out_q : '0;
`else
    assign data_out = data_out_q;
`endif

    assign out_valid = out_valid_q;
    assign primed    = (fill_q == depth_q);
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_shift_row_buf.sv
// tb/tb_shift_row_buf.sv - Table-driven self-checking bench for shift_row_buf

module tb_shift_row_buf;

    localparam int DATA_W    = 16;
    localparam int MAX_DEPTH = 256;
    localparam int PTR_W     = 8;

`ifdef SHIFT_ROW_BUF_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_load;
    logic [PTR_W:0]    cfg_depth;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic              primed;
    logic [PTR_W:0]    fill_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic              rst_n;
        logic              cfg_load;
        logic [PTR_W:0]    cfg_depth;
        logic              in_valid;
        logic [DATA_W-1:0] data_in;
        logic              ov;
        logic [DATA_W-1:0] d;
        logic              dcare;
        logic              pr;
        logic [PTR_W:0]    fc;
    } vec_t;

    vec_t vecs[$];

    shift_row_buf #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .cfg_depth(cfg_depth),
        .in_valid (in_valid),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out),
        .primed   (primed),
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic cl, input int cd, input logic iv,
                       input int di, input logic ov, input int d, input logic dc,
                       input logic pr, input int fc);
        vec_t v;
        v.rst_n = r; v.cfg_load = cl; v.cfg_depth = (PTR_W+1)'(cd);
        v.in_valid = iv; v.data_in = DATA_W'(di);
        v.ov = ov; v.d = DATA_W'(d); v.dcare = dc; v.pr = pr; v.fc = (PTR_W+1)'(fc);
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the edge
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst_n = v.rst_n; cfg_load = v.cfg_load; cfg_depth = v.cfg_depth;
        in_valid = v.in_valid; data_in = v.data_in;
        @(posedge clk);
        #1;
        cmp({tag, " out_valid"}, int'(out_valid), int'(v.ov));
        cmp({tag, " primed"},    int'(primed),    int'(v.pr));
        cmp({tag, " fill_cnt"},  int'(fill_cnt),  int'(v.fc));
        if (ZP && !v.ov)
            cmp({tag, " data_out"}, int'(data_out), 0);
        else if (v.ov || v.dcare)
            cmp({tag, " data_out"}, int'(data_out), int'(v.d));
    endtask

    // Long fill to MAX_DEPTH: first output must be the first sample
    task automatic big_pass(input bit do_cfg, input int cd, input int base, input string tag);
        vec_t v;
        if (do_cfg) begin
            v = '{1'b1, 1'b1, (PTR_W+1)'(cd), 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0};
            run_vec(v, {tag, " cfg"});
        end
        for (int i = 1; i <= MAX_DEPTH + 1; i++) begin
            v.rst_n = 1'b1; v.cfg_load = 1'b0; v.cfg_depth = '0; v.in_valid = 1'b1;
            v.data_in = DATA_W'(base + i - 1);
            v.ov = (i == MAX_DEPTH + 1);
            v.d = DATA_W'(base);
            v.dcare = v.ov;
            v.pr = (i >= MAX_DEPTH);
            v.fc = (PTR_W+1)'((i >= MAX_DEPTH) ? MAX_DEPTH : i);
            run_vec(v, $sformatf("%s acc%0d", tag, i));
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_depth = '0; in_valid = 1'b0; data_in = '0;

        // depth 4, continuous stream 1..7, then an idle gap
        add(0,0,0,0,0,   0,0,1, 0,0);
        add(1,1,4,0,0,   0,0,1, 0,0);
        for (int k = 1; k <= 7; k++)
            add(1,0,0,1,k, (k >= 5), k-4, 1'b0, (k >= 4), (k >= 4) ? 4 : k);
        add(1,0,0,0,77,  0,3,1, 1,4);

        // depth 3, sparse accepts 10,_,_,11,12,_,13
        add(1,1,3,0,0,   0,0,0, 0,0);
        add(1,0,0,1,10,  0,0,0, 0,1);
        add(1,0,0,0,55,  0,0,0, 0,1);
        add(1,0,0,0,56,  0,0,0, 0,1);
        add(1,0,0,1,11,  0,0,0, 0,2);
        add(1,0,0,1,12,  0,0,0, 1,3);
        add(1,0,0,0,57,  0,0,0, 1,3);
        add(1,0,0,1,13,  1,10,1, 1,3);
        add(1,0,0,0,58,  0,10,1, 1,3);

        // depth 1, data 5,6,7
        add(1,1,1,0,0,   0,0,0, 0,0);
        add(1,0,0,1,5,   0,0,0, 1,1);
        add(1,0,0,1,6,   1,5,1, 1,1);
        add(1,0,0,1,7,   1,6,1, 1,1);
        add(1,0,0,0,0,   0,6,1, 1,1);

        // depth 8 streaming, then flush to depth 2 with in_valid high
        add(1,1,8,0,0,   0,0,0, 0,0);
        for (int k = 1; k <= 10; k++)
            add(1,0,0,1,19+k, (k >= 9), 11+k, 1'b0, (k >= 8), (k >= 8) ? 8 : k);
        add(1,1,2,1,99,  0,0,0, 0,0);
        add(1,0,0,1,40,  0,0,0, 0,1);
        add(1,0,0,1,41,  0,0,0, 1,2);
        add(1,0,0,1,42,  1,40,1, 1,2);
        add(1,0,0,1,43,  1,41,1, 1,2);

        // reset mid-stream overrides cfg_load and in_valid
        add(0,1,3,1,50,  0,0,1, 0,0);

        foreach (vecs[i])
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // after reset the depth is MAX_DEPTH without any cfg_load
        big_pass(1'b0, 0, 100, "rstdepth");
        big_pass(1'b1, 0, 1000, "cfg0");
        big_pass(1'b1, MAX_DEPTH + 5, 2000, "cfgbig");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
